// File: rtl/aemb_ifetch.sv
// Purpose: instruction fetch front-end; Wishbone-classic read into a one-word buffer, decoded on gena.
// Latency: >= 3 cycles per instruction (IDLE, FETCH with same-cycle ack, HOLD with gena).
// Backpressure: the buffered word is held in HOLD with fetch_rdy=1 until gena; a hung bus is cut off by the watchdog.
module aemb_ifetch #(
  parameter logic [7:0]  TOUT     = 8'd255,
  parameter logic [31:0] NOP_INST = 32'h8000_0000
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  output logic        fetch_rdy,
  output logic        fetch_tout,
  input  logic        rBRA,
  input  logic        rDLY,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [10:0] rALT,
  output logic [31:0] rSIMM,
  output logic        rIMMV
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [5:0] OPC_IMM = 6'o54;

  state_t      state;
  logic [7:0]  wdog;
  logic [31:0] ibuf;
  logic [15:0] immhi;

  // A taken branch without a delay slot kills the word sitting in the buffer.
  logic        squash;
  logic [31:0] inst;

  assign squash = rBRA & ~rDLY;
  assign inst   = squash ? NOP_INST : ibuf;

  // Fetch sequencer: IDLE lets the PC address settle, FETCH strobes the bus, HOLD waits for gena.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state      <= IDLE;
      iwb_stb_o  <= 1'b0;
      fetch_rdy  <= 1'b0;
      fetch_tout <= 1'b0;
      wdog       <= 8'd0;
      ibuf       <= NOP_INST;
    end else begin
      fetch_tout <= 1'b0;
      case (state)
        IDLE: begin
          state     <= FETCH;
          iwb_stb_o <= 1'b1;
          wdog      <= 8'd0;
        end
        FETCH: begin
          if (iwb_ack_i) begin
            // An ack on the expiry cycle still wins over the timeout.
            ibuf      <= iwb_dat_i;
            state     <= HOLD;
            iwb_stb_o <= 1'b0;
            fetch_rdy <= 1'b1;
          end else if (wdog == TOUT) begin
            ibuf       <= NOP_INST;
            fetch_tout <= 1'b1;
            state      <= HOLD;
            iwb_stb_o  <= 1'b0;
            fetch_rdy  <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        HOLD: begin
          if (gena) begin
            state     <= IDLE;
            fetch_rdy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          iwb_stb_o <= 1'b0;
          fetch_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Decode registers: updated only when the pipeline advances out of HOLD.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rOPC  <= 6'o40;
      rRD   <= 5'd0;
      rRA   <= 5'd0;
      rRB   <= 5'd0;
      rALT  <= 11'd0;
      rSIMM <= 32'd0;
      rIMMV <= 1'b0;
      immhi <= 16'd0;
    end else if (gena && state == HOLD) begin
      rOPC  <= inst[31:26];
      rRD   <= inst[25:21];
      rRA   <= inst[20:16];
      rRB   <= inst[15:11];
      rALT  <= inst[10:0];
      rSIMM <= rIMMV ? {immhi, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
      if (inst[31:26] == OPC_IMM && !squash) begin
        immhi <= inst[15:0];
        rIMMV <= 1'b1;
      end else begin
        rIMMV <= 1'b0;
      end
    end
  end

  // gena is only legal while a word is buffered.
  a_gena_in_hold: assert property (@(posedge gclk) disable iff (grst) gena |-> (state == HOLD));

endmodule

// File: doc/aemb_ifetch.md
Name: aemb_ifetch

Overview:
- Instruction fetch and decode front-end, directly upstream of the branch/PC unit.
- Issues Wishbone-classic instruction reads at the address the PC unit drives, and holds one fetched word in a single-entry buffer.
- On each pipeline advance (gena), decodes the buffered word into opcode, register fields and a 32-bit immediate. These feed the PC unit and the ALU.
- Squashes the word after a non-delayed taken branch, merges IMM-prefix immediates, and recovers from a hung bus with a watchdog.

Parameters:
- TOUT, 8'd255: ack-wait cycles before the fetch is abandoned.
- NOP_INST, 32'h80000000: instruction substituted on squash or timeout (OR r0,r0,r0).

Ports:
- gclk  in  1  clock
- grst  in  1  synchronous active-high reset
- gena  in  1  pipeline advance; asserted only while fetch_rdy=1
- iwb_stb_o  out  1  instruction bus strobe
- iwb_ack_i  in  1  instruction bus acknowledge
- iwb_dat_i  in  32  instruction read data
- fetch_rdy  out  1  buffer holds a valid word; feeds the core's gena qualification
- fetch_tout  out  1  one-cycle pulse when the watchdog expires
- rBRA  in  1  branch taken, from PC unit
- rDLY  in  1  branch has delay slot, from PC unit
- rOPC  out  6  decoded opcode, inst[31:26]
- rRD  out  5  inst[25:21]
- rRA  out  5  inst[20:16]
- rRB  out  5  inst[15:11]
- rALT  out  11  inst[10:0]
- rSIMM  out  32  resolved immediate
- rIMMV  out  1  IMM prefix pending for the next decoded instruction

Behaviour:
- Reset: grst is sampled on the gclk rising edge and has priority over everything else. After reset:
  - state=IDLE, iwb_stb_o=0, fetch_rdy=0, fetch_tout=0, watchdog=0, buffer=NOP_INST.
  - rOPC=6'o40, rRD=rRA=rRB=0, rALT=0, rSIMM=0, rIMMV=0, IMM-high latch=0.
- State machine (IDLE, FETCH, HOLD):
  - IDLE: the next cycle goes to FETCH. IDLE lasts exactly one cycle so the PC unit's address settles.
  - FETCH: iwb_stb_o=1. On iwb_ack_i=1, capture iwb_dat_i into the buffer and go to HOLD; iwb_stb_o is 0 from the next cycle.
  - FETCH with no ack: the watchdog increments each cycle. When watchdog==TOUT and there is still no ack, load NOP_INST into the buffer, pulse fetch_tout for one cycle, and go to HOLD. An ack arriving in that same cycle wins: the data is captured and no timeout is flagged.
  - HOLD: fetch_rdy=1 and iwb_stb_o=0. On gena=1, go to IDLE. The PC unit updates its fetch address on that same edge.
  - The watchdog clears on entry to FETCH.
- Throughput: at least 3 cycles per instruction (IDLE, FETCH with same-cycle ack, HOLD with gena).
- Stray ack: iwb_ack_i outside FETCH is ignored, including a late ack after a reset mid-fetch.
- gena outside HOLD: ignored; no decode-register update. This is a protocol violation and is flagged by an assertion.
- Decode update, on the gena edge while in HOLD:
  - Squash: squash = rBRA & ~rDLY, sampled on that edge. If squash, NOP_INST is decoded instead of the buffer.
  - Fields: rOPC/rRD/rRA/rRB/rALT are taken from the selected word.
  - rSIMM when rIMMV=1: {immhi, inst[15:0]}.
  - rSIMM when rIMMV=0: sign-extended inst[15:0], i.e. {{16{inst[15]}}, inst[15:0]}.
  - IMM prefix: if the selected word has opcode 6'o54 and is not squashed, immhi<=inst[15:0] and rIMMV<=1.
  - Otherwise rIMMV<=0. Consequences:
    - Back-to-back IMMs: the second IMM overwrites immhi.
    - A squashed word decodes as NOP, so it clears rIMMV.
- Timeout-substituted NOP: decodes normally, with no other side effect.
- Widths: all fields are direct bit slices; no arithmetic other than the watchdog counter, which never wraps because it stops at TOUT.

Test Plan:
- Reset then ack on 1st FETCH cycle with iwb_dat_i=32'h3021_FFFC (addik r1,r1,-4) -> iwb_stb_o high for exactly 1 cycle; fetch_rdy high. On gena: rOPC=6'o14, rRD=1, rRA=1, rSIMM=32'hFFFF_FFFC, rIMMV=0.
- IMM 32'hB000_1234 then 32'h3060_5678, each gena'd -> after the 1st gena rIMMV=1. After the 2nd: rSIMM=32'h1234_5678, rIMMV=0.
- Fetch 32'h3021_FFFC with rBRA=1, rDLY=0 at gena -> rOPC=6'o40, rRD=0, rRA=0, rRB=0, rSIMM=0. Repeat with rDLY=1 -> the word decodes normally.
- Ack withheld, TOUT=4 -> stb high 5 cycles; fetch_tout pulses once; fetch_rdy rises; gena decodes rOPC=6'o40. Then ack on the watchdog==TOUT cycle -> data captured, no fetch_tout.
- Assert grst during FETCH, then ack 1 cycle after reset release -> ack ignored; IDLE then FETCH with fresh stb; all outputs at reset values until the next gena.
- Hold fetch_rdy for 10 cycles with gena=0 -> decode outputs stable; iwb_stb_o=0 throughout; no new fetch issued.
